// File: rtl/rv_index_to_onehot.sv
// Combinational binary-index to one-hot decode with out-of-range flag.
// REVERSE mirrors the bit order so index 0 selects the MSB.
module rv_index_to_onehot #(
    parameter int N = 5,
    parameter bit REVERSE = 1'b0,
    localparam int LN = (N > 1) ? $clog2(N) : 1
) (
    input  logic [LN-1:0] index,
    output logic [N-1:0]  onehot,
    output logic          err
);

    // Only reachable when N is not a power of two (or N==1 with index 1).
    assign err = ({{(32-LN){1'b0}}, index} >= 32'(N));

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_bit
            localparam int SEL = REVERSE ? (N - 1 - gi) : gi;
            assign onehot[gi] = !err && (index == LN'(SEL));
        end
    endgenerate

endmodule

// File: rtl/rv_onehot_decoder.sv
// Registered index-to-one-hot decoder with valid/ready on both sides and a
// one-entry skid buffer so throughput holds under output backpressure.
module rv_onehot_decoder #(
    parameter int N = 5,
    parameter bit REVERSE = 1'b0,
    localparam int LN = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [LN-1:0] in_index,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_onehot,
    output logic          out_err,
    output logic          out_busy
);

    logic [N-1:0] dec_onehot;
    logic         dec_err;

    logic         main_valid_reg, main_valid_next;
    logic [N-1:0] main_onehot_reg, main_onehot_next;
    logic         main_err_reg, main_err_next;
    logic         skid_valid_reg, skid_valid_next;
    logic [N-1:0] skid_onehot_reg, skid_onehot_next;
    logic         skid_err_reg, skid_err_next;

    logic in_fire;
    logic out_fire;

    rv_index_to_onehot #(
        .N       (N),
        .REVERSE (REVERSE)
    ) u_dec (
        .index  (in_index),
        .onehot (dec_onehot),
        .err    (dec_err)
    );

    // Ready depends only on held state, never on out_ready.
    assign in_ready   = !skid_valid_reg;
    assign in_fire    = in_valid && in_ready;
    assign out_fire   = main_valid_reg && out_ready;

    assign out_valid  = main_valid_reg;
    assign out_onehot = main_onehot_reg;
    assign out_err    = main_err_reg;
    assign out_busy   = main_valid_reg | skid_valid_reg;

    always_comb begin
        main_valid_next  = main_valid_reg;
        main_onehot_next = main_onehot_reg;
        main_err_next    = main_err_reg;
        skid_valid_next  = skid_valid_reg;
        skid_onehot_next = skid_onehot_reg;
        skid_err_next    = skid_err_reg;

        if (skid_valid_reg) begin
            // Skid full: input is blocked; drain skid into main when main leaves.
            if (out_ready) begin
                main_valid_next  = 1'b1;
                main_onehot_next = skid_onehot_reg;
                main_err_next    = skid_err_reg;
                skid_valid_next  = 1'b0;
            end
        end else if (in_fire) begin
            if (!main_valid_reg || out_ready) begin
                main_valid_next  = 1'b1;
                main_onehot_next = dec_onehot;
                main_err_next    = dec_err;
            end else begin
                skid_valid_next  = 1'b1;
                skid_onehot_next = dec_onehot;
                skid_err_next    = dec_err;
            end
        end else if (out_fire) begin
            main_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_valid_reg  <= 1'b0;
            main_onehot_reg <= '0;
            main_err_reg    <= 1'b0;
            skid_valid_reg  <= 1'b0;
            skid_onehot_reg <= '0;
            skid_err_reg    <= 1'b0;
        end else begin
            main_valid_reg  <= main_valid_next;
            main_onehot_reg <= main_onehot_next;
            main_err_reg    <= main_err_next;
            skid_valid_reg  <= skid_valid_next;
            skid_onehot_reg <= skid_onehot_next;
            skid_err_reg    <= skid_err_next;
        end
    end

endmodule

// File: tb/tb_rv_onehot_decoder.sv
// Directed and randomized-handshake checks of rv_onehot_decoder in three
// configurations: N=5 forward, N=5 reversed, N=6 forward.
module tb_rv_onehot_decoder;

    logic clk;
    logic reset;

    // N=5, REVERSE=0
    logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_err, a_out_busy;
    logic [2:0] a_in_index;
    logic [4:0] a_out_onehot;
    // N=5, REVERSE=1
    logic       r_in_valid, r_in_ready, r_out_valid, r_out_ready, r_out_err, r_out_busy;
    logic [2:0] r_in_index;
    logic [4:0] r_out_onehot;
    // N=6, REVERSE=0
    logic       n_in_valid, n_in_ready, n_out_valid, n_out_ready, n_out_err, n_out_busy;
    logic [2:0] n_in_index;
    logic [5:0] n_out_onehot;

    int n_cmp;
    int n_bad;

    rv_onehot_decoder #(.N(5), .REVERSE(1'b0)) u_fwd (
        .clk(clk), .reset(reset),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_index(a_in_index),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_onehot(a_out_onehot),
        .out_err(a_out_err), .out_busy(a_out_busy)
    );

    rv_onehot_decoder #(.N(5), .REVERSE(1'b1)) u_rev (
        .clk(clk), .reset(reset),
        .in_valid(r_in_valid), .in_ready(r_in_ready), .in_index(r_in_index),
        .out_valid(r_out_valid), .out_ready(r_out_ready), .out_onehot(r_out_onehot),
        .out_err(r_out_err), .out_busy(r_out_busy)
    );

    rv_onehot_decoder #(.N(6), .REVERSE(1'b0)) u_n6 (
        .clk(clk), .reset(reset),
        .in_valid(n_in_valid), .in_ready(n_in_ready), .in_index(n_in_index),
        .out_valid(n_out_valid), .out_ready(n_out_ready), .out_onehot(n_out_onehot),
        .out_err(n_out_err), .out_busy(n_out_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [4:0] exp_fwd [5];
    logic [5:0] exp_n6;
    logic [5:0] q [$];
    int sent, rcv, cur;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        exp_fwd = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000};

        reset = 1'b1;
        a_in_valid = 0; a_in_index = '0; a_out_ready = 0;
        r_in_valid = 0; r_in_index = '0; r_out_ready = 0;
        n_in_valid = 0; n_in_index = '0; n_out_ready = 0;
        #2;
        check("rst_valid",  a_out_valid,  0);
        check("rst_onehot", a_out_onehot, 0);
        check("rst_err",    a_out_err,    0);
        check("rst_ready",  a_in_ready,   1);
        check("rst_busy",   a_out_busy,   0);
        step();
        reset = 1'b0;
        step();

        // Back-to-back indices 0..4, consumer always ready.
        a_out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a_in_valid = 1'b1;
            a_in_index = 3'(i);
            check("b2b_in_ready", a_in_ready, 1);
            step();
            check("b2b_valid",  a_out_valid,  1);
            check("b2b_onehot", a_out_onehot, exp_fwd[i]);
            $display("txn fwd idx=%0d onehot=%b", i, a_out_onehot);
        end
        a_in_valid = 1'b0;
        step();
        check("b2b_drain_valid", a_out_valid, 0);

        // Reversed bit order.
        r_out_ready = 1'b1;
        r_in_valid = 1'b1;
        r_in_index = 3'd1;
        step();
        check("rev_idx1", r_out_onehot, 5'b01000);
        $display("txn rev idx=1 onehot=%b", r_out_onehot);
        r_in_index = 3'd4;
        step();
        check("rev_idx4", r_out_onehot, 5'b00001);
        $display("txn rev idx=4 onehot=%b", r_out_onehot);
        r_in_valid = 1'b0;

        // Out-of-range index, then a legal one.
        a_in_valid = 1'b1;
        a_in_index = 3'd6;
        step();
        check("oor_valid",  a_out_valid,  1);
        check("oor_onehot", a_out_onehot, 0);
        check("oor_err",    a_out_err,    1);
        $display("txn fwd idx=6 onehot=%b err=%b", a_out_onehot, a_out_err);
        a_in_index = 3'd2;
        step();
        check("after_oor_onehot", a_out_onehot, 5'b00100);
        check("after_oor_err",    a_out_err,    0);
        $display("txn fwd idx=2 onehot=%b err=%b", a_out_onehot, a_out_err);
        a_in_valid = 1'b0;
        step();

        // Backpressure fills main then skid; release drains in order.
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_index  = 3'd3;
        step();
        check("bp_ready_main_only", a_in_ready, 1);
        a_in_index = 3'd0;
        step();
        a_in_valid = 1'b0;
        check("bp_ready_full", a_in_ready,   0);
        check("bp_main",       a_out_onehot, 5'b01000);
        check("bp_busy",       a_out_busy,   1);
        step();
        check("bp_hold_valid",  a_out_valid,  1);
        check("bp_hold_onehot", a_out_onehot, 5'b01000);
        $display("txn fwd bp head onehot=%b", a_out_onehot);
        a_out_ready = 1'b1;
        step();
        check("bp_second",        a_out_onehot, 5'b00001);
        check("bp_second_valid",  a_out_valid,  1);
        check("bp_ready_restore", a_in_ready,   1);
        $display("txn fwd bp tail onehot=%b", a_out_onehot);
        step();
        check("bp_empty_valid", a_out_valid, 0);
        check("bp_empty_busy",  a_out_busy,  0);

        // Asynchronous reset between edges while main and skid are both full.
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_index  = 3'd1;
        step();
        a_in_index = 3'd2;
        step();
        a_in_valid = 1'b0;
        check("arst_pre_ready", a_in_ready, 0);
        #2;
        reset = 1'b1;
        #1;
        check("arst_valid",  a_out_valid,  0);
        check("arst_onehot", a_out_onehot, 0);
        check("arst_busy",   a_out_busy,   0);
        check("arst_ready",  a_in_ready,   1);
        reset = 1'b0;
        a_in_valid  = 1'b1;
        a_in_index  = 3'd4;
        a_out_ready = 1'b1;
        step();
        check("arst_post_valid",  a_out_valid,  1);
        check("arst_post_onehot", a_out_onehot, 5'b10000);
        $display("txn fwd post-reset idx=4 onehot=%b", a_out_onehot);
        a_in_valid = 1'b0;
        step();

        // Random handshakes on N=6: scoreboard of decoded indices.
        sent = 0;
        rcv  = 0;
        cur  = $urandom_range(0, 5);
        for (int cyc = 0; cyc < 20000 && rcv < 1000; cyc++) begin
            n_in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
            n_in_index  = 3'(cur);
            n_out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            check("n6_popcount", 32'($countones(n_out_onehot) <= 1), 1);
            check("n6_state",    32'(n_out_busy && !n_out_valid), 0);
            if (n_out_valid && n_out_ready) begin
                if (q.size() == 0) begin
                    check("n6_extra_output", q.size(), 1);
                end else begin
                    exp_n6 = q.pop_front();
                    check("n6_data", n_out_onehot, exp_n6);
                    check("n6_err",  n_out_err,    0);
                    $display("txn n6 #%0d onehot=%b", rcv, n_out_onehot);
                end
                rcv++;
            end
            if (n_in_valid && n_in_ready) begin
                q.push_back(6'd1 << cur);
                sent++;
                cur = $urandom_range(0, 5);
            end
            step();
        end
        n_in_valid = 1'b0;
        check("n6_received", rcv, 1000);
        check("n6_leftover", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
